mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the m_* request interface driven by the data cache and its uncached bypass path: m_a, m_din, m_strobe, m_rw, m_wen, m_size, m_dout, m_ready.
- Accepts one request at a time, serves it from an internal byte-lane word memory after a programmable wait, and answers with a single-cycle m_ready.
- Sits below the cache as the simulation/FPGA main-memory model. Also serves as the template for later bus bridges.

Parameters:
- A_WIDTH, 32, address width.
- MEM_AW, 10, log2 of memory depth in 32-bit words.
- BASE_TAG, 0, required value of m_a[A_WIDTH-1:MEM_AW+2] for an in-range access.
- RD_LAT, 2, cycles from request acceptance to m_ready for reads; must be >= 1.
- WR_LAT, 1, the same for writes; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- m_a  in  A_WIDTH  byte address from initiator.
- m_din  in  32  write data from initiator.
- m_strobe  in  1  request valid.
- m_rw  in  1  0 = read, 1 = write.
- m_wen  in  4  byte write enables; bit3 = [31:24] ... bit0 = [7:0].
- m_size  in  2  0 = byte, 1 = half, 2 = word; checked only.
- m_dout  out  32  read data.
- m_ready  out  1  completion pulse.
- m_err  out  1  error flag, qualified by m_ready.

Behaviour:
- Single clock, clk. Reset clrn is asynchronous, active-low.
- On reset:
  - state = IDLE.
  - m_ready = 0, m_err = 0, m_dout = 0, wait counter = 0.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If m_strobe = 1 at a clock edge, latch m_a, m_din, m_rw, m_wen and m_size. This is acceptance in cycle T.
  - Next state is RESP if LAT = 1, otherwise WAIT with counter = LAT-2.
  - LAT = WR_LAT when m_rw = 1, RD_LAT otherwise.
- WAIT: decrement the counter; when the counter = 0, go to RESP.
- RESP:
  - m_ready = 1 for exactly one cycle, cycle T+LAT.
  - Next state is always IDLE.
- Outputs m_ready, m_dout and m_err are registered; no combinational path from any input.
- Reads:
  - m_dout is loaded with the word at index latched_a[MEM_AW+1:2] on the edge entering RESP.
  - m_dout holds its value afterwards until the next read completes.
  - Writes do not change m_dout.
- Writes:
  - Each byte lane with latched wen bit = 1 is written on the edge entering RESP.
  - wen = 0000 completes with m_ready and changes nothing.
- m_err is set with m_ready when any of these holds:
  - latched_a[A_WIDTH-1:MEM_AW+2] != BASE_TAG.
  - Misalignment: size 1 with a[0] = 1, or size 2 with a[1:0] != 0.
  - m_size = 3.
- On m_err:
  - The access is suppressed: no write, and read data = 32'h0.
  - m_ready still pulses.
- The handshake is level-sampled only in IDLE:
  - The initiator holds the request stable until m_ready.
  - Inputs are ignored in WAIT and RESP.
  - Dropping m_strobe mid-request does not cancel it; m_ready still pulses.
- m_strobe still high in the cycle after m_ready (IDLE) is accepted as a new request. The minimum request-to-request spacing is therefore LAT+1 cycles.
- Read-after-write to the same word returns the new data.
- Reset asserted in WAIT or RESP:
  - Aborts the request immediately.
  - No m_ready pulse.
  - No write is committed unless the RESP entry edge already occurred.

Decomposition:
- Shared package:
  - Size encodings SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2.
  - Request-type constants RW_READ = 0, RW_WRITE = 1.
  - FSM state encoding for IDLE/WAIT/RESP.
- One sub-module, mem_byte_ram:
  - Four 8-bit lane arrays of depth 2^MEM_AW.
  - Synchronous write per lane enable; synchronous read.
  - Keeps the FSM/counter/check logic in mem_responder separate from storage.

Test Plan:
- Reset: hold clrn = 0, drive m_strobe = 1 -> m_ready = 0, m_err = 0, m_dout = 0; after release, the first acceptance occurs on the first edge.
- Word write then read (RD_LAT = 2, WR_LAT = 1):
  - sw of 32'h1234_5678 to 0x0000_0040 -> m_ready at T+1.
  - lw from the same address -> m_ready at T+2, m_dout = 32'h1234_5678, m_err = 0.
- Byte lanes: from 32'h1234_5678, write wen = 0100 with data 32'h00AB_0000 -> read returns 32'h12AB_5678; then wen = 0011 with data 32'h0000_CDEF -> 32'h12AB_CDEF.
- Errors:
  - Read of 0x0001_0000 (tag mismatch, MEM_AW = 10) -> m_ready with m_err = 1, m_dout = 0.
  - Word write to 0x42 -> m_err = 1, and memory is unchanged on readback.
- Back-to-back: m_strobe held high across two reads to 0x0 and 0x4 -> m_ready pulses exactly at T+2 and T+5, with correct data each time.
- Reset mid-request: write accepted, clrn pulled low during WAIT (WR_LAT = 3) -> no m_ready; a later read of that word returns the old value.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: access sizes, request type,
// FSM states and the access-legality helper.
package mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Width of the wait counter; latencies up to 2^CNT_W + 1 are representable.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when the size code is illegal or the address is not aligned to it.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] a_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a_lo[0];
      SZ_WORD: bad = (a_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the cache-side initiator and the memory responder.
interface mem_responder_if #(
  parameter int A_WIDTH = 32
);
  logic [A_WIDTH-1:0] m_a;
  logic [31:0]        m_din;
  logic               m_strobe;
  logic               m_rw;
  logic [3:0]         m_wen;
  logic [1:0]         m_size;
  logic [31:0]        m_dout;
  logic               m_ready;
  logic               m_err;

  modport master (
    output m_a, m_din, m_strobe, m_rw, m_wen, m_size,
    input  m_dout, m_ready, m_err
  );

  modport slave (
    input  m_a, m_din, m_strobe, m_rw, m_wen, m_size,
    output m_dout, m_ready, m_err
  );
endinterface

// File: rtl/mem_responder_byte_ram.sv
// Word memory built from four independent byte lanes with a synchronous,
// enable-gated read register that can be forced to zero.
module mem_byte_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  input  logic          rd_en_i,
  input  logic          rd_zero_i,
  output logic [31:0]   rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem_q [2**AW];
    logic [7:0] rd_q;

    // NOTE: the storage array has no reset branch so it maps onto block RAM;
    // only the read register below is cleared.
    always_ff @(posedge clk) begin
      if (we_i[l]) mem_q[addr_i] <= wdata_i[8*l +: 8];
    end

    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        rd_q <= 8'h00;
      end else if (rd_en_i) begin
        rd_q <= rd_zero_i ? 8'h00 : mem_q[addr_i];
      end
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request at a time, waits RD_LAT/WR_LAT
// cycles, then completes it with a single-cycle m_ready.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                        A_WIDTH  = 32,
  parameter int                        MEM_AW   = 10,
  parameter logic [A_WIDTH-MEM_AW-3:0] BASE_TAG = '0,
  parameter int                        RD_LAT   = 2,   // must be >= 1
  parameter int                        WR_LAT   = 1    // must be >= 1
) (
  input  logic            clk,
  input  logic            clrn,
  mem_responder_if.slave  bus_s
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 2);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 2);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [A_WIDTH-1:0] a_q;
  logic [31:0]        din_q;
  logic               rw_q;
  logic [3:0]         wen_q;
  logic [1:0]         size_q;
  logic               ready_q;
  logic               err_q;

  logic               in_idle;
  logic [A_WIDTH-1:0] req_a;
  logic [31:0]        req_din;
  logic               req_rw;
  logic [3:0]         req_wen;
  logic [1:0]         req_size;
  logic               req_err;
  logic               req_lat_one;
  logic               enter_resp;

  // When LAT = 1 the RESP entry edge is the acceptance edge itself, so the
  // access must come straight from the bus while still in IDLE.
  assign in_idle  = (state_q == ST_IDLE);
  assign req_a    = in_idle ? bus_s.m_a    : a_q;
  assign req_din  = in_idle ? bus_s.m_din  : din_q;
  assign req_rw   = in_idle ? bus_s.m_rw   : rw_q;
  assign req_wen  = in_idle ? bus_s.m_wen  : wen_q;
  assign req_size = in_idle ? bus_s.m_size : size_q;

  assign req_err = (req_a[A_WIDTH-1:MEM_AW+2] != BASE_TAG)
                 || access_bad(req_size, req_a[1:0]);

  assign req_lat_one = (req_rw == RW_WRITE) ? (WR_LAT == 1) : (RD_LAT == 1);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_s.m_strobe) begin
          if (req_lat_one) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = (req_rw == RW_WRITE) ? WR_LOAD : RD_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_d == ST_RESP);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      din_q   <= '0;
      rw_q    <= RW_READ;
      wen_q   <= '0;
      size_q  <= SZ_BYTE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && bus_s.m_strobe) begin
        a_q    <= bus_s.m_a;
        din_q  <= bus_s.m_din;
        rw_q   <= bus_s.m_rw;
        wen_q  <= bus_s.m_wen;
        size_q <= bus_s.m_size;
      end
      ready_q <= enter_resp;
      err_q   <= enter_resp && req_err;
    end
  end

  mem_byte_ram #(
    .AW (MEM_AW)
  ) u_ram (
    .clk       (clk),
    .clrn      (clrn),
    .addr_i    (req_a[MEM_AW+1:2]),
    .we_i      ((enter_resp && req_rw == RW_WRITE && !req_err) ? req_wen : 4'b0000),
    .wdata_i   (req_din),
    .rd_en_i   (enter_resp && req_rw == RW_READ),
    .rd_zero_i (req_err),
    .rdata_o   (bus_s.m_dout)
  );

  assign bus_s.m_ready = ready_q;
  assign bus_s.m_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed bench for mem_responder against a word-array model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk = 1'b0;
  logic clrn0 = 1'b0;
  logic clrn3 = 1'b0;
  logic sel3 = 1'b0;

  logic [31:0] m_a = '0;
  logic [31:0] m_din = '0;
  logic        m_strobe = 1'b0;
  logic        m_rw = 1'b0;
  logic [3:0]  m_wen = '0;
  logic [1:0]  m_size = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.A_WIDTH(32)) bus0 ();
  mem_responder_if #(.A_WIDTH(32)) bus3 ();

  assign bus0.m_a = m_a;      assign bus3.m_a = m_a;
  assign bus0.m_din = m_din;  assign bus3.m_din = m_din;
  assign bus0.m_rw = m_rw;    assign bus3.m_rw = m_rw;
  assign bus0.m_wen = m_wen;  assign bus3.m_wen = m_wen;
  assign bus0.m_size = m_size; assign bus3.m_size = m_size;
  assign bus0.m_strobe = m_strobe & ~sel3;
  assign bus3.m_strobe = m_strobe & sel3;

  mem_responder #(.A_WIDTH(32), .MEM_AW(10), .BASE_TAG('0), .RD_LAT(2), .WR_LAT(1))
    dut0 (.clk(clk), .clrn(clrn0), .bus_s(bus0));
  mem_responder #(.A_WIDTH(32), .MEM_AW(10), .BASE_TAG('0), .RD_LAT(2), .WR_LAT(3))
    dut3 (.clk(clk), .clrn(clrn3), .bus_s(bus3));

  logic        obs_ready, obs_err;
  logic [31:0] obs_dout;
  assign obs_ready = sel3 ? bus3.m_ready : bus0.m_ready;
  assign obs_err   = sel3 ? bus3.m_err   : bus0.m_err;
  assign obs_dout  = sel3 ? bus3.m_dout  : bus0.m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic rw,
                       input logic [3:0] wen, input logic [1:0] size);
    m_a = a; m_din = d; m_rw = rw; m_wen = wen; m_size = size; m_strobe = 1'b1;
  endtask

  // Waits for the acceptance edge, scrambles the (ignored) inputs, then checks
  // that m_ready pulses exactly LAT cycles later for exactly one cycle.
  task automatic wait_resp(input string tag, input int lat, input logic exp_err,
                           input logic [31:0] exp_dout);
    int early;
    early = 0;
    @(posedge clk);
    #1;
    m_strobe = 1'b0;
    m_a = $urandom; m_din = $urandom; m_rw = 1'($urandom);
    m_wen = 4'($urandom); m_size = 2'($urandom);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if (obs_ready) early++;
    end
    @(negedge clk);
    check({tag, ":early"}, 32'(early), 32'd0);
    check({tag, ":ready"}, {31'd0, obs_ready}, 32'd1);
    check({tag, ":err"}, {31'd0, obs_err}, {31'd0, exp_err});
    check({tag, ":dout"}, obs_dout, exp_dout);
    @(negedge clk);
    check({tag, ":pulse"}, {31'd0, obs_ready}, 32'd0);
  endtask

  task automatic req(input string tag, input logic [31:0] a, input logic [31:0] d,
                     input logic rw, input logic [3:0] wen, input logic [1:0] size,
                     input int lat, input logic exp_err, input logic [31:0] exp_dout);
    drive(a, d, rw, wen, size);
    wait_resp(tag, lat, exp_err, exp_dout);
  endtask

  logic [31:0] model_mem [16];
  logic [31:0] last_dout;
  logic [5:0]  rdy_seen;

  initial begin
    // Reset with a request already pending on the bus.
    drive(32'h40, 32'h1234_5678, RW_WRITE, 4'b1111, SZ_WORD);
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus0.m_ready}, 32'd0);
    check("rst_err", {31'd0, bus0.m_err}, 32'd0);
    check("rst_dout", bus0.m_dout, 32'd0);
    clrn0 = 1'b1;
    wait_resp("rst_sw", 1, 1'b0, 32'd0);

    req("lw0", 32'h40, 32'h0, RW_READ, 4'b0000, SZ_WORD, 2, 1'b0, 32'h1234_5678);
    req("sb", 32'h42, 32'h00AB_0000, RW_WRITE, 4'b0100, SZ_BYTE, 1, 1'b0, 32'h1234_5678);
    req("lw1", 32'h40, 32'h0, RW_READ, 4'b0000, SZ_WORD, 2, 1'b0, 32'h12AB_5678);
    req("sh", 32'h40, 32'h0000_CDEF, RW_WRITE, 4'b0011, SZ_HALF, 1, 1'b0, 32'h12AB_5678);
    req("lw2", 32'h40, 32'h0, RW_READ, 4'b0000, SZ_WORD, 2, 1'b0, 32'h12AB_CDEF);

    // Error cases: the access is suppressed but still completes.
    req("tag_err", 32'h0001_0000, 32'h0, RW_READ, 4'b0000, SZ_WORD, 2, 1'b1, 32'h0);
    req("mis_sw", 32'h42, 32'hFFFF_FFFF, RW_WRITE, 4'b1111, SZ_WORD, 1, 1'b1, 32'h0);
    req("lw3", 32'h40, 32'h0, RW_READ, 4'b0000, SZ_WORD, 2, 1'b0, 32'h12AB_CDEF);
    req("wen0", 32'h40, 32'hFFFF_FFFF, RW_WRITE, 4'b0000, SZ_WORD, 1, 1'b0, 32'h12AB_CDEF);
    req("lw4", 32'h40, 32'h0, RW_READ, 4'b0000, SZ_WORD, 2, 1'b0, 32'h12AB_CDEF);

    // Back-to-back reads with m_strobe held high.
    req("sw_b0", 32'h0, 32'hA5A5_0001, RW_WRITE, 4'b1111, SZ_WORD, 1, 1'b0, 32'h12AB_CDEF);
    req("sw_b1", 32'h4, 32'h5A5A_0002, RW_WRITE, 4'b1111, SZ_WORD, 1, 1'b0, 32'h12AB_CDEF);
    drive(32'h0, 32'h0, RW_READ, 4'b0000, SZ_WORD);
    @(posedge clk);
    rdy_seen = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      rdy_seen[k-1] = bus0.m_ready;
      if (k == 1) m_a = 32'h4;
      if (k == 2) check("b2b_d0", bus0.m_dout, 32'hA5A5_0001);
      if (k == 5) begin
        check("b2b_d1", bus0.m_dout, 32'h5A5A_0002);
        m_strobe = 1'b0;
      end
    end
    check("b2b_ready", 32'(rdy_seen), 32'b010010);
    last_dout = 32'h5A5A_0002;

    // Random traffic over 16 words at 0x100, checked against a word model.
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      req("init", 32'h100 + 32'(i * 4), model_mem[i], RW_WRITE, 4'b1111, SZ_WORD,
          1, 1'b0, last_dout);
    end
    for (int n = 0; n < 60; n++) begin
      int          idx;
      logic [1:0]  lo, size;
      logic        rw, bad_tag, err;
      logic [3:0]  wen;
      logic [31:0] a, d, exp;
      idx     = $urandom_range(0, 15);
      lo      = 2'($urandom_range(0, 3));
      size    = 2'($urandom_range(0, 3));
      rw      = 1'($urandom_range(0, 1));
      wen     = 4'($urandom);
      d       = $urandom;
      bad_tag = ($urandom_range(0, 7) == 0);
      a       = 32'h100 + 32'(idx * 4) + {30'd0, lo};
      if (bad_tag) a[31:12] = 20'($urandom_range(1, 1048575));
      err = bad_tag || (size == 2'd3) || (size == 2'd1 && lo[0]) || (size == 2'd2 && lo != 2'd0);
      if (rw) begin
        exp = last_dout;
        if (!err)
          for (int b = 0; b < 4; b++)
            if (wen[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp = err ? 32'h0 : model_mem[idx];
        last_dout = exp;
      end
      req(rw ? "rnd_wr" : "rnd_rd", a, d, rw, wen, size, rw ? 1 : 2, err, exp);
    end

    // Reset during WAIT on the WR_LAT = 3 instance aborts the write.
    sel3 = 1'b1;
    @(negedge clk);
    clrn3 = 1'b1;
    req("l3_sw", 32'h80, 32'hCAFE_F00D, RW_WRITE, 4'b1111, SZ_WORD, 3, 1'b0, 32'h0);
    req("l3_lw", 32'h80, 32'h0, RW_READ, 4'b0000, SZ_WORD, 2, 1'b0, 32'hCAFE_F00D);
    drive(32'h80, 32'hDEAD_BEEF, RW_WRITE, 4'b1111, SZ_WORD);
    @(posedge clk);
    #1 m_strobe = 1'b0;
    @(negedge clk);
    #1 clrn3 = 1'b0;
    rdy_seen = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rdy_seen[k] = bus3.m_ready;
    end
    check("abort_ready", 32'(rdy_seen), 32'd0);
    check("abort_dout", bus3.m_dout, 32'd0);
    clrn3 = 1'b1;
    req("abort_lw", 32'h80, 32'h0, RW_READ, 4'b0000, SZ_WORD, 2, 1'b0, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
